uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx.sv | 102 ++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default bit timing used by both directions.
// Timing: 19.0 MHz / 16 / 19200 baud -> tick every 62 clk, 16 ticks per bit.
package uart_pkg;

   localparam int unsigned DEFAULT_DIVIDER    = 61;
   localparam int unsigned DEFAULT_OVERSAMPLE = 15;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular FIFO with occupancy counter; data_ready-style accept flag is registered and low in reset.
// Zero-latency read of the head; a push while full is ignored, push+pop together keep occupancy.
module uart_tx_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [width-1:0] rdata_o,
   output logic             ready_o,
   output logic             empty_o
);

   localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = $clog2(depth + 1);

   logic [width-1:0] mem_q [depth];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             ready_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Ready looks at next occupancy so it is valid on the first edge after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d != CW'(depth));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign ready_o = ready_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; tx falls one edge after a byte lands in an idle, empty queue.
// Back-pressure via data_ready (low while FIFO full); queued frames go out back-to-back with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned divider    = DEFAULT_DIVIDER,
   parameter int unsigned oversample = DEFAULT_OVERSAMPLE,
   parameter int unsigned fifo_depth = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned TW = (divider > 0) ? $clog2(divider + 1) : 1;
   localparam int unsigned SW = (oversample > 0) ? $clog2(oversample + 1) : 1;

   tx_state_t     state_q;
   logic [TW-1:0] tick_q;
   logic [SW-1:0] samp_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_q;
   logic          tx_q;

   logic          tick;
   logic          bit_end;
   logic          fifo_pop;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;

   uart_tx_fifo #(
      .width (8),
      .depth (fifo_depth)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (data_valid),
      .wdata_i (data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .ready_o (data_ready),
      .empty_o (fifo_empty)
   );

   assign tick     = (tick_q == TW'(divider));
   assign bit_end  = tick && (samp_q == SW'(oversample));
   assign fifo_pop = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         samp_q  <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         tick_q <= tick ? '0 : tick_q + 1'b1;
         if (tick) samp_q <= (samp_q == SW'(oversample)) ? '0 : samp_q + 1'b1;

         // Every START entry (from IDLE or straight out of STOP) realigns the bit timers.
         if (fifo_pop) begin
            state_q <= START;
            shift_q <= fifo_rdata;
            tx_q    <= 1'b0;
            tick_q  <= '0;
            samp_q  <= '0;
         end else if (bit_end) begin
            case (state_q)
               START: begin
                  state_q <= DATA;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
               end
               DATA: begin
                  shift_q <= shift_q >> 1;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                     tx_q  <= shift_q[1];
                  end
               end
               STOP: begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with divider=1, oversample=3 (8 clk per bit, 80 clk per frame).
// A frame-level model predicts tx/busy/data_ready every cycle; a line decoder recovers bytes.
module tb_uart_tx;

   localparam int BIT   = 8;
   localparam int FRAME = 80;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic       tx;
   logic       busy;

   int vectors = 0;
   int errors  = 0;

   uart_tx #(
      .divider    (1),
      .oversample (3),
      .fifo_depth (DEPTH)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: queue of accepted bytes, current frame as 10 line bits and elapsed clocks.
   logic [7:0] mq[$];
   logic [9:0] fr = 10'h3FF;
   logic [7:0] m_byte;
   int         cyc = 0;
   bit         act = 1'b0;
   bit         m_rdy = 1'b0;
   bit         m_push;
   int unsigned ncyc = 0;

   always @(posedge clk) begin
      ncyc++;
      if (!reset) begin
         mq.delete();
         act   = 1'b0;
         cyc   = 0;
         m_rdy = 1'b0;
      end else begin
         m_push = data_valid && m_rdy;
         if (act) begin
            cyc++;
            if (cyc == FRAME) act = 1'b0;
         end
         if (!act && mq.size() > 0) begin
            m_byte = mq.pop_front();
            fr     = {1'b1, m_byte, 1'b0};
            act    = 1'b1;
            cyc    = 0;
         end
         if (m_push) mq.push_back(data);
         m_rdy = (mq.size() != DEPTH);
      end
   end

   logic e_tx, e_busy, e_rdy;
   always @(negedge clk) begin
      if (!reset) begin
         e_tx = 1'b1; e_busy = 1'b0; e_rdy = 1'b0;
      end else begin
         e_tx   = act ? fr[cyc / BIT] : 1'b1;
         e_busy = act || (mq.size() != 0);
         e_rdy  = m_rdy;
      end
      vectors++;
      if ({tx, busy, data_ready} !== {e_tx, e_busy, e_rdy}) begin
         errors++;
         $display("FAIL cycle %0d tx/busy/ready: got %b%b%b, expected %b%b%b",
                  ncyc, tx, busy, data_ready, e_tx, e_busy, e_rdy);
      end
   end

   // Line decoder: samples bit centres after each detected start bit.
   logic [7:0] rxq[$];
   logic [7:0] rx_sh = 8'h00;
   bit         rx_on = 1'b0;
   int         rx_cnt = 0;
   int         rx_frm_err = 0;

   always @(negedge clk) begin
      if (!reset) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= 12 && rx_cnt <= 68 && (rx_cnt % BIT) == 4) rx_sh = {tx, rx_sh[7:1]};
         if (rx_cnt == 76) begin
            rx_on = 1'b0;
            if (tx === 1'b1) rxq.push_back(rx_sh);
            else rx_frm_err++;
         end
      end
   end

   logic [7:0] expq[$];

   task automatic check_rx(input string name);
      chk({name, "_count"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) chk({name, "_byte"}, rxq[i], expq[i]);
      rxq.delete();
      expq.delete();
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; holds byte and data_valid until data_ready is seen, returns after the accepting edge.
   task automatic send(input logic [7:0] b, output int acc);
      int n;
      n = 0;
      data = b;
      data_valid = 1'b1;
      while (data_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("send_accepted_in_time", int'(n < 2000), 1);
      acc = ncyc;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   int a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   logic [7:0] burst[6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h33, 8'hC3};
   logic [7:0] bp[6]    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C};

   initial begin
      int t0, c, bad;
      int t[6];

      wait_n(3);
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_ready", data_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_first_edge", data_ready, 1);

      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) bad++;
      end
      chk("idle_1000", bad, 0);

      send(8'hA5, t0);
      chk("a5_tx_after_accept", tx, 1);
      @(negedge clk);
      c = 0;
      chk("a5_tx_low_next_edge", tx, 0);
      for (int k = 0; k < 10; k++) begin
         wait_n(8 * k + 4 - c);
         c = 8 * k + 4;
         chk("a5_line_bit", tx, a5_seq[k]);
      end
      wait_n(79 - c);
      chk("a5_busy_last_cycle", busy, 1);
      @(negedge clk);
      chk("a5_busy_fall", busy, 0);
      expq.push_back(8'hA5);
      wait_n(5);
      check_rx("single");

      for (int i = 0; i < 6; i++) send(burst[i], t[i]);
      chk("burst_second_consec", t[1] - t[0], 1);
      chk("burst_fifth_consec", t[4] - t[0], 4);
      chk("burst_sixth_after_pop", t[5] - t[0], 82);
      wait_n(6 * FRAME);
      chk("burst_busy_done", busy, 0);
      for (int i = 0; i < 6; i++) expq.push_back(burst[i]);
      check_rx("burst");

      for (int i = 0; i < 5; i++) send(bp[i], t0);
      chk("bp_ready_low_when_full", data_ready, 0);
      send(bp[5], t0);
      wait_n(6 * FRAME);
      for (int i = 0; i < 6; i++) expq.push_back(bp[i]);
      check_rx("backpressure");

      send(8'h5A, t0);
      send(8'h6B, t0);
      send(8'h7C, t0);
      wait_n(78);
      chk("pp_stop_bit_high", tx, 1);
      data = 8'h8D;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      chk("pp_occupancy_kept", u_dut.u_fifo.count_q, 2);
      chk("pp_start_next_edge", tx, 0);
      chk("pp_ready_high", data_ready, 1);
      wait_n(4 * FRAME);
      expq.push_back(8'h5A); expq.push_back(8'h6B);
      expq.push_back(8'h7C); expq.push_back(8'h8D);
      check_rx("push_pop");

      send(8'h81, t0);
      send(8'h12, t0);
      send(8'h34, t0);
      wait_n(30);
      chk("mid_data_bit_low", tx, 0);
      #2 reset = 1'b0;
      #1;
      chk("abort_tx_high", tx, 1);
      chk("abort_busy_low", busy, 0);
      chk("abort_ready_low", data_ready, 0);
      wait_n(3);
      reset = 1'b1;
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("abort_no_more_frames", bad, 0);
      check_rx("abort");
      chk("rx_framing", rx_frm_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
